// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-sharing of one three-digit
// 7-segment display between two byte requesters. The granted value is
// converted to BCD by a sequential double-dabble engine, then shown with
// leading-zero blanking and held for a minimum readable time.

`ifndef WORD_SIZE_p
`define WORD_SIZE_p 8
`endif

module seg_display_scheduler #(
  parameter int WIDTH       = `WORD_SIZE_p,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ack,
  output logic [7:0]       D2,
  output logic [7:0]       D1,
  output logic [7:0]       D0,
  output logic             src,
  output logic             busy,
  output logic             done
);

  // Hold counter is loaded with HOLD_CYCLES-1 and counts down to zero,
  // so it only needs enough bits for that load value.
  localparam int HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad =
    HoldW'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [11:0]      bcd_q;
  logic [3:0]       bitCnt_q;
  logic [HoldW-1:0] holdCnt_q;
  logic             srcCap_q;
  logic             rrPtr_q;
  logic [7:0]       d2_q;
  logic [7:0]       d1_q;
  logic [7:0]       d0_q;
  logic             src_q;
  logic             done_q;

  logic             transfer;
  logic [11:0]      bcdAdj;
  logic [11:0]      bcd_d;
  logic [WIDTH-1:0] bin_d;

  // Active-low segment pattern for one decimal digit, decimal point off.
  function automatic logic [7:0] segOf(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3.
  function automatic logic [11:0] addThree(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (b[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Grant logic: only in IDLE and never during reset; when both requesters
  // wait, the pointer picks the one that was not served last.
  always_comb begin
    req_ack = 2'b00;
    if (state_q == IDLE && !rst) begin
      case (req_valid)
        2'b01:   req_ack = 2'b01;
        2'b10:   req_ack = 2'b10;
        2'b11:   req_ack = rrPtr_q ? 2'b10 : 2'b01;
        default: req_ack = 2'b00;
      endcase
    end
  end

  assign transfer = |(req_valid & req_ack);

  // One double-dabble step: correct the BCD nibbles, then shift the
  // combined {bcd, bin} register left by one.
  always_comb begin
    bcdAdj = addThree(bcd_q);
    bcd_d  = (bcdAdj << 1) | {11'b0, bin_q[WIDTH-1]};
    bin_d  = bin_q << 1;
  end

  // Main sequencer: capture, convert, load display, hold, back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      bitCnt_q  <= '0;
      holdCnt_q <= '0;
      srcCap_q  <= 1'b0;
      rrPtr_q   <= 1'b0;
      d2_q      <= 8'hFF;
      d1_q      <= 8'hFF;
      d0_q      <= 8'hFF;
      src_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (transfer) begin
            bin_q    <= req_ack[1] ? req_data1 : req_data0;
            bcd_q    <= '0;
            srcCap_q <= req_ack[1];
            rrPtr_q  <= ~req_ack[1];
            bitCnt_q <= 4'(WIDTH);
            state_q  <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q    <= bcd_d;
          bin_q    <= bin_d;
          bitCnt_q <= bitCnt_q - 4'd1;
          if (bitCnt_q == 4'd1) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          d2_q   <= (bcd_q[11:8] == 4'd0) ? 8'hFF : segOf(bcd_q[11:8]);
          d1_q   <= (bcd_q[11:4] == 8'd0) ? 8'hFF : segOf(bcd_q[7:4]);
          d0_q   <= segOf(bcd_q[3:0]);
          src_q  <= srcCap_q;
          done_q <= 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_q <= IDLE;
          end else begin
            holdCnt_q <= HoldLoad;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (holdCnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            holdCnt_q <= holdCnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D2   = d2_q;
  assign D1   = d1_q;
  assign D0   = d0_q;
  assign src  = src_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Time-shares one three-digit 7-segment display between two byte requesters, for example the UART RX data byte (requester 0) and the TX data byte (requester 1).
- Arbitrates round-robin between the requesters.
- Converts the granted unsigned value to BCD with a sequential shift-add-3 (double-dabble) engine, then drives registered active-low segment codes with leading-zero blanking.
- Holds each value on the display for a programmable minimum time so it is readable.

Parameters:
- WIDTH, default `WORD_SIZE_p (8): bit width of request data. Legal range is 1..9, so the maximum value 511 fits in three digits.
- HOLD_CYCLES, default 50_000_000: minimum number of clock cycles a value stays displayed before the next grant. 0 is legal.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester "value pending" flag.
- req_data0  input  WIDTH  requester 0 value.
- req_data1  input  WIDTH  requester 1 value.
- req_ack  output  2  one-hot grant; a transfer occurs on the edge where req_valid[i] && req_ack[i].
- D2  output  8  hundreds-digit segments, active-low.
- D1  output  8  tens-digit segments, active-low.
- D0  output  8  units-digit segments, active-low.
- src  output  1  requester whose value is currently displayed.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse in the cycle the display registers update.

Behaviour:
- Segment codes, decimal point off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank = FF.
- Reset (asynchronous, any state):
  - Outputs: D2=D1=D0=FF, src=0, done=0, busy=0, req_ack=0.
  - Internals: state=IDLE, round-robin pointer favours requester 0.
  - An in-flight conversion is discarded and never displayed.
- req_ack is combinational:
  - Nonzero only in IDLE, and only when some req_valid bit is set.
  - Exactly one bit is ever set.
  - Arbitration: if only one requester is valid, grant it. If both are valid, grant the one not granted last.
  - The pointer updates only on an actual transfer.
- States:
  - IDLE: on a transfer, capture the granted data into the shift register, clear the BCD register to 0, record the source, set the bit counter to WIDTH, and go to CONVERT.
  - CONVERT: each cycle, first add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by 1 and decrement the counter. After exactly WIDTH cycles, go to LOAD.
  - LOAD (1 cycle):
    - Register D2/D1/D0 from the BCD nibbles. Update src and assert done.
    - Blanking: D2=FF when hundreds==0. D1=FF when hundreds==0 and tens==0. D0 is always shown, so value 0 displays as FF FF C0.
    - Next state: HOLD, or IDLE if HOLD_CYCLES==0.
  - HOLD: count HOLD_CYCLES cycles, then go to IDLE. Requests stay pending; req_ack=0 throughout.
- Latency: D* update on the edge WIDTH+1 cycles after the transfer edge, at the end of the LOAD cycle. The first possible next transfer is in the cycle after HOLD completes.
- Data capture: req_data is sampled only on the transfer edge; later changes have no effect. req_valid dropping before a grant means nothing is transferred.
- Out-of-range hundreds digit cannot occur when WIDTH<=9. WIDTH outside 1..9 is a configuration error.

Test Plan:
- Reset, then req_valid=01 and req_data0=8'd7 → req_ack=01 for one cycle; 9 cycles later D2=FF, D1=FF, D0=F8, src=0, done=1 for 1 cycle.
- req_data1=8'd255 on requester 1 → D2=A4, D1=92, D0=92, src=1. Then 8'd100 → F9, C0, C0. Then 8'd0 → FF, FF, C0. Then 8'd40 → FF, 99, C0.
- Both requesters held valid with HOLD_CYCLES=4 → grants alternate 01, 10, 01. Successive transfers are exactly WIDTH+1+4+1 cycles apart. busy stays high between grants.
- Assert rst mid-CONVERT after a 8'd123 transfer → outputs return to FF/FF/FF immediately, done is never pulsed, and the next grant goes to requester 0.
- WIDTH=9, value 511 → 92, F9, F9. With HOLD_CYCLES=0, a second pending request is acked in the cycle after LOAD.
- Change req_data0 during CONVERT → the displayed value equals the value captured at the transfer edge.
